// File: rtl/lift_pkg.sv
// Shared types and defaults for the lift controller.
// Holds the FSM state enum, default parameters and a one-hot checker.
package lift_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      ARRIVE,
      DOOR_OPEN,
      DWELL,
      DOOR_CLOSE,
      FAULT
   } state_t;

   localparam int DEF_NUM_FLOORS   = 6;
   localparam int DEF_DWELL_CYCLES = 8;
   localparam int DEF_OPEN_TIMEOUT = 64;

   // True when exactly one bit is set (callers zero-extend).
   function automatic logic is_one_hot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/lift_req_latch.sv
// Latched floor-call register for the lift controller.
// Ports: clk, reset (async, high); request (call buttons); floor (one-hot
// car position); mask (ignore calls at floor); clear (drop call at floor);
// pending (latched calls); hit (masked call seen at current floor).
module lift_req_latch
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS = DEF_NUM_FLOORS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] request,
   input  logic [NUM_FLOORS-1:0] floor,
   input  logic                  mask,
   input  logic                  clear,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  hit
);

   logic [NUM_FLOORS-1:0] keep_out;
   logic [NUM_FLOORS-1:0] drop;

   assign keep_out = mask ? floor : '0;
   assign drop     = clear ? floor : '0;
   assign hit      = mask && |(request & floor);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         pending <= (pending | (request & ~keep_out)) & ~drop;
      end
   end

endmodule

// File: rtl/lift_controller.sv
// Moore FSM lift controller: serves latched calls, runs the door cycle.
// Ports: clk, reset (async, high); Request, Sensor, Passenger_in in;
// MoveUp, MoveDown, OpenDoor, CloseDoor, stop, Pending, Fault out.
module lift_controller
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS   = DEF_NUM_FLOORS,
   parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
   parameter int OPEN_TIMEOUT = DEF_OPEN_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] Request,
   input  logic [NUM_FLOORS-1:0] Sensor,
   input  logic                  Passenger_in,
   output logic                  MoveUp,
   output logic                  MoveDown,
   output logic                  OpenDoor,
   output logic                  CloseDoor,
   output logic                  stop,
   output logic [NUM_FLOORS-1:0] Pending,
   output logic                  Fault
);

   localparam int CNT_MAX = (DWELL_CYCLES > OPEN_TIMEOUT) ?
                            DWELL_CYCLES : OPEN_TIMEOUT;
   localparam int CW = $clog2(CNT_MAX + 1);

   typedef logic [CW-1:0] cnt_t;

   state_t state, next_state;
   logic   dir, next_dir;
   cnt_t   cnt, next_cnt;

   logic [NUM_FLOORS-1:0] prev_sensor;
   logic [NUM_FLOORS-1:0] at_or_below;
   logic [NUM_FLOORS-1:0] below_mask;
   logic valid, moved, here, above, below;
   logic hit, mask_cur, clear_cur, restart;
   logic up_d, down_d, open_d, close_d, stop_d, fault_d;

   // For a one-hot Sensor, (Sensor<<1)-1 covers the car floor and below;
   // at the top floor the shift wraps to 0 so nothing lies above.
   assign at_or_below = {Sensor[NUM_FLOORS-2:0], 1'b0} - NUM_FLOORS'(1);
   assign below_mask  = Sensor - NUM_FLOORS'(1);

   assign valid = is_one_hot(32'(Sensor));
   assign moved = (Sensor != prev_sensor);
   assign here  = |(Pending & Sensor);
   assign above = |(Pending & ~at_or_below);
   assign below = |(Pending & below_mask);

   assign mask_cur  = (state == ARRIVE) || (state == DOOR_OPEN) ||
                      (state == DWELL);
   assign clear_cur = (state == ARRIVE);
   assign restart   = hit && (state == DWELL);

   lift_req_latch #(
      .NUM_FLOORS(NUM_FLOORS)
   ) u_req (
      .clk    (clk),
      .reset  (reset),
      .request(Request),
      .floor  (Sensor),
      .mask   (mask_cur),
      .clear  (clear_cur),
      .pending(Pending),
      .hit    (hit)
   );

   always_comb begin
      next_state = state;
      next_dir   = dir;
      next_cnt   = '0;
      unique case (state)
         IDLE: begin
            if (here) begin
               next_state = ARRIVE;
            end else if (above && (dir || !below)) begin
               next_state = MOVE_UP;
               next_dir   = 1'b1;
            end else if (below) begin
               next_state = MOVE_DOWN;
               next_dir   = 1'b0;
            end else begin
               next_dir = 1'b1;
            end
         end
         MOVE_UP: begin
            if (moved && here)
               next_state = ARRIVE;
            else if (Sensor[NUM_FLOORS-1])
               next_state = IDLE;
         end
         MOVE_DOWN: begin
            if (moved && here)
               next_state = ARRIVE;
            else if (Sensor[0])
               next_state = IDLE;
         end
         ARRIVE: next_state = DOOR_OPEN;
         DOOR_OPEN: begin
            if (Passenger_in)
               next_state = DWELL;
            else if (cnt == CW'(OPEN_TIMEOUT - 1))
               next_state = FAULT;
            else
               next_cnt = cnt + cnt_t'(1);
         end
         DWELL: begin
            if (restart)
               next_cnt = '0;
            else if (cnt == CW'(DWELL_CYCLES - 1))
               next_state = DOOR_CLOSE;
            else
               next_cnt = cnt + cnt_t'(1);
         end
         DOOR_CLOSE: next_state = IDLE;
         FAULT:      next_state = FAULT;
         default:    next_state = FAULT;
      endcase
      if (!valid)
         next_state = FAULT;
   end

   // Outputs are decoded from next_state and registered alongside it.
   always_comb begin
      up_d    = 1'b0;
      down_d  = 1'b0;
      open_d  = 1'b0;
      close_d = 1'b0;
      stop_d  = 1'b1;
      fault_d = 1'b0;
      unique case (next_state)
         MOVE_UP: begin
            up_d   = 1'b1;
            stop_d = 1'b0;
         end
         MOVE_DOWN: begin
            down_d = 1'b1;
            stop_d = 1'b0;
         end
         DOOR_OPEN:  open_d  = 1'b1;
         DOOR_CLOSE: close_d = 1'b1;
         FAULT:      fault_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         dir         <= 1'b1;
         cnt         <= '0;
         prev_sensor <= '0;
         MoveUp      <= 1'b0;
         MoveDown    <= 1'b0;
         OpenDoor    <= 1'b0;
         CloseDoor   <= 1'b0;
         stop        <= 1'b1;
         Fault       <= 1'b0;
      end else begin
         state       <= next_state;
         dir         <= next_dir;
         cnt         <= next_cnt;
         prev_sensor <= Sensor;
         MoveUp      <= up_d;
         MoveDown    <= down_d;
         OpenDoor    <= open_d;
         CloseDoor   <= close_d;
         stop        <= stop_d;
         Fault       <= fault_d;
      end
   end

endmodule

// File: doc/lift_controller.md
LIFT_CONTROLLER -- requirements
Module: lift_controller

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 6, number of floors (one-hot width of Sensor/Request).
REQ-002 SHALL have parameter DWELL_CYCLES, default 8, clock cycles the door stays open after Passenger_in rises.
REQ-003 SHALL have parameter OPEN_TIMEOUT, default 64, max cycles in DOOR_OPEN waiting for Passenger_in.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports clk and reset.
REQ-005 clk  input  1  rising-edge system clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 Request  input  NUM_FLOORS  floor call buttons, level, sampled every cycle.
REQ-008 Sensor  input  NUM_FLOORS  one-hot current car floor from the lift unit.
REQ-009 Passenger_in  input  1  door-cycle-complete indication from the lift unit.
REQ-010 MoveUp, MoveDown, OpenDoor, CloseDoor, stop  output  1 each  commands to the lift unit.
REQ-011 Pending  output  NUM_FLOORS  latched unserved calls.
REQ-012 Fault  output  1  sticky error flag.

Function
REQ-013 All outputs SHALL be registered (Moore); command changes take effect on the clock edge after the triggering input is sampled.
REQ-014 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, ARRIVE, DOOR_OPEN, DWELL, DOOR_CLOSE, FAULT.
REQ-015 Pending SHALL be set by Pending |= Request every cycle, except a bit for the current floor while in ARRIVE/DOOR_OPEN/DWELL, which restarts the dwell counter instead (DWELL only).
REQ-016 IDLE: Pending[cur] set -> ARRIVE; else pending above and (dir=up or none below) -> MOVE_UP, dir=up; else pending below -> MOVE_DOWN, dir=down; else stay; dir resets to up.
REQ-017 MOVE_UP/MOVE_DOWN: MoveUp/MoveDown=1, stop=0; on each Sensor change, if Pending[new floor] -> ARRIVE.
REQ-018 MoveUp SHALL never be 1 while Sensor[NUM_FLOORS-1]=1; MoveDown never while Sensor[0]=1; reaching an end floor with no pending bit there -> IDLE.
REQ-019 ARRIVE: one cycle, all move commands 0, stop=1; clears Pending[cur]; -> DOOR_OPEN.
REQ-020 DOOR_OPEN: OpenDoor=1, stop=1 until Passenger_in=1 -> DWELL; OPEN_TIMEOUT cycles without it -> FAULT.
REQ-021 DWELL: stop=1, all commands 0, count DWELL_CYCLES then -> DOOR_CLOSE.
REQ-022 DOOR_CLOSE: CloseDoor=1, stop=1 for exactly one cycle -> IDLE.
REQ-023 Sensor not one-hot (zero or multi-bit) in any state SHALL -> FAULT next cycle.
REQ-024 FAULT: stop=1, Fault=1, all other commands 0; exit only by reset.
REQ-025 MoveUp and MoveDown SHALL never be 1 together; OpenDoor/CloseDoor SHALL only be 1 with stop=1.

Reset
REQ-026 On reset: state=IDLE, dir=up, counters 0, Pending=0, Fault=0, MoveUp=MoveDown=OpenDoor=CloseDoor=0, stop=1.
REQ-027 Reset asserted mid-operation SHALL abort immediately to the REQ-026 values; pending calls are discarded.

Structure
REQ-028 Package lift_pkg SHALL hold the state enum, default NUM_FLOORS/DWELL_CYCLES/OPEN_TIMEOUT constants and a one-hot-check function.
REQ-029 One sub-module lift_req_latch SHALL hold the Pending register with set/clear/current-floor masking; counters and FSM stay in lift_controller.

Verification
REQ-030 Reset, Sensor=000001, Request=001000 one cycle -> MOVE_UP, MoveUp=1 stop=0 until Sensor=001000, then ARRIVE, OpenDoor=1, Pending=0.
REQ-031 Car at 000001 moving up, Requests 000100 and 100000, then 000010 while passing 000100 -> stops at floor 2 and floor 5 in order, floor 1 served after reversing down.
REQ-032 DOOR_OPEN, Passenger_in=1 at cycle 3 -> DWELL exactly 8 cycles, CloseDoor=1 one cycle, then IDLE; current-floor Request during DWELL restarts count.
REQ-033 Sensor=100000 moving up, no pending -> MoveUp drops next edge, never asserted at top floor.
REQ-034 Sensor=000000 or 010010 -> FAULT, Fault=1, stop=1; persists until reset.
REQ-035 Passenger_in held 0 in DOOR_OPEN for 64 cycles -> FAULT; reset mid-MOVE_DOWN -> all outputs at REQ-026 values same cycle.
